secret_number_ctrl: RTL and testbench

//  Sequences the 4-digit LFSR random number generator for a bulls-and-cows round.
//  On a new-game request it waits for the LFSR to advance and pulses gen_enable.
//  It then captures the generator output and checks it: every digit 0-9, all four distinct.

---
 rtl/bc_pkg.sv | 22 ++
 rtl/bc_digit_checker.sv | 26 ++
 rtl/secret_number_ctrl.sv | 107 ++++++++++
 tb/tb_secret_number_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared definitions for the bulls-and-cows secret generation and guess checking.
package bc_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int SECRET_W   = DIGIT_W * NUM_DIGITS;

    // Secret used when the generator keeps producing unusable numbers.
    localparam logic [SECRET_W-1:0] FALLBACK_SECRET = 16'h1234;

    // Largest legal BCD digit value.
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GAP     = 3'd1,
        REQ     = 3'd2,
        CAPTURE = 3'd3,
        CHECK   = 3'd4
    } state_t;

endpackage

// File: rtl/bc_digit_checker.sv
// Combinational validity check for a 4-digit bulls-and-cows number:
// every digit must be 0-9 and all digits must differ from each other.
module bc_digit_checker
    import bc_pkg::*;
(
    input  logic [SECRET_W-1:0] cand,
    output logic                ok
);

    // Range check on every digit, then the six pairwise inequality compares.
    always_comb begin
        // NOTE: ok gets a value before any conditional update so no latch is inferred.
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cand[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX) begin
                ok = 1'b0;
            end
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (cand[i*DIGIT_W +: DIGIT_W] == cand[j*DIGIT_W +: DIGIT_W]) begin
                    ok = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/secret_number_ctrl.sv
// Sequences the LFSR generator for a new round: wait for the LFSR to advance,
// request a number, validate it, retry a bounded number of times, and hold the
// accepted (or fallback) secret stable for the downstream game logic.
module secret_number_ctrl
    import bc_pkg::*;
#(
    parameter int unsigned SEED_GAP  = 4,
    parameter int unsigned MAX_RETRY = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic [15:0] rnd_in,
    output logic        gen_enable,
    output logic [15:0] secret,
    output logic        secret_valid,
    output logic        busy,
    output logic [3:0]  retry_cnt,
    output logic        fallback_used
);

    localparam logic [3:0] GAP_LAST  = 4'(SEED_GAP - 1);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    state_t         state;
    state_t         state_next;
    logic [3:0]     gap_cnt;
    logic [15:0]    cand;
    logic           cand_ok;
    logic           retry_left;

    bc_digit_checker u_checker (
        .cand (cand),
        .ok   (cand_ok)
    );

    assign retry_left = (retry_cnt < RETRY_MAX);

    // Both outputs are pure decodes of the state register, so they carry no extra latency.
    assign gen_enable = (state == REQ);
    assign busy       = (state != IDLE);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (new_game) state_next = GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_next = REQ;
            REQ:     state_next = CAPTURE;
            CAPTURE: state_next = CHECK;
            CHECK:   state_next = (!cand_ok && retry_left) ? GAP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: gap timer, candidate capture, retry bookkeeping and the held secret.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt       <= '0;
            retry_cnt     <= '0;
            cand          <= '0;
            secret        <= '0;
            secret_valid  <= 1'b0;
            fallback_used <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_game) begin
                        // Old secret stays visible (but invalid) until a new one is accepted.
                        gap_cnt       <= '0;
                        retry_cnt     <= '0;
                        fallback_used <= 1'b0;
                        secret_valid  <= 1'b0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                CAPTURE: begin
                    cand <= rnd_in;
                end
                CHECK: begin
                    if (cand_ok) begin
                        secret       <= cand;
                        secret_valid <= 1'b1;
                    end else if (retry_left) begin
                        retry_cnt <= retry_cnt + 4'd1;
                        gap_cnt   <= '0;
                    end else begin
                        secret        <= FALLBACK_SECRET;
                        fallback_used <= 1'b1;
                        secret_valid  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_secret_number_ctrl.sv
// Self-checking bench for secret_number_ctrl with a behavioural model of a
// generation round: candidate list in, expected pulses/latency/secret out.
module tb_secret_number_ctrl;

    localparam int G  = 4;       // SEED_GAP of the DUT
    localparam int MR = 3;       // MAX_RETRY of the DUT
    localparam int P  = G + 3;   // cycles per attempt

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_game = 1'b0;
    logic [15:0] rnd_in = 16'h0000;
    logic        gen_enable;
    logic [15:0] secret;
    logic        secret_valid;
    logic        busy;
    logic [3:0]  retry_cnt;
    logic        fallback_used;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] cand_q[$];          // candidates delivered per attempt
    logic [15:0] m_secret = 16'h0;   // model of the currently held secret

    secret_number_ctrl #(.SEED_GAP(G), .MAX_RETRY(MR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .new_game      (new_game),
        .rnd_in        (rnd_in),
        .gen_enable    (gen_enable),
        .secret        (secret),
        .secret_valid  (secret_valid),
        .busy          (busy),
        .retry_cnt     (retry_cnt),
        .fallback_used (fallback_used)
    );

    always #5 clk = ~clk;

    // A number is usable if each decimal digit is 0-9 and no digit is seen twice.
    function automatic bit model_ok(input logic [15:0] v);
        bit [9:0] seen = '0;
        int d;
        for (int i = 0; i < 4; i++) begin
            d = int'((v >> (4 * i)) & 16'hF);
            if (d > 9) return 1'b0;
            if (seen[d]) return 1'b0;
            seen[d] = 1'b1;
        end
        return 1'b1;
    endfunction

    // Random number with four distinct decimal digits (partial shuffle of 0..9).
    function automatic logic [15:0] rand_valid();
        logic [3:0] d[10];
        logic [3:0] t;
        int j;
        for (int i = 0; i < 10; i++) d[i] = 4'(i);
        for (int i = 9; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = d[i]; d[i] = d[j]; d[j] = t;
        end
        return {d[3], d[2], d[1], d[0]};
    endfunction

    // One full generation round driven from cand_q, checked against the model.
    task automatic run_gen(input string name, input bit noise);
        int          n_att;
        bit          acc;
        logic [15:0] exp_sec;
        int          exp_retry;
        bit          exp_fb;
        int          gen_seen;
        int          gen_bad;
        int          valid_edge;
        int          hold_bad;

        acc = 1'b0; n_att = 0; exp_sec = 16'h0;
        for (int j = 0; j <= MR && !acc; j++) begin
            n_att++;
            if (model_ok(cand_q[j])) begin
                acc = 1'b1;
                exp_sec = cand_q[j];
            end
        end
        if (acc) begin
            exp_retry = n_att - 1; exp_fb = 1'b0;
        end else begin
            exp_retry = MR; exp_fb = 1'b1; exp_sec = 16'h1234;
        end

        @(negedge clk);
        new_game = 1'b1;
        rnd_in   = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b0;

        gen_seen = 0; gen_bad = 0; valid_edge = -1; hold_bad = 0;
        for (int e = 0; e < n_att * P + 10; e++) begin
            if (gen_enable) begin
                if (e != gen_seen * P + G) gen_bad++;
                if (gen_seen < cand_q.size()) rnd_in = cand_q[gen_seen];
                gen_seen++;
            end
            if (valid_edge < 0) begin
                if (secret_valid) valid_edge = e;
                else if (secret !== m_secret || busy !== 1'b1) hold_bad++;
            end
            if (noise && valid_edge < 0 && busy) new_game = 1'($urandom_range(1, 0));
            else                                 new_game = 1'b0;
            if (valid_edge >= 0 && e >= valid_edge + 3) break;
            @(posedge clk);
            @(negedge clk);
        end
        new_game = 1'b0;

        n_tests++;
        if (gen_seen != n_att) begin
            n_fail++; $display("FAIL %s gen_count: got %0d expected %0d", name, gen_seen, n_att);
        end
        n_tests++;
        if (gen_bad != 0) begin
            n_fail++; $display("FAIL %s gen_timing: %0d misplaced pulses, expected 0", name, gen_bad);
        end
        n_tests++;
        if (valid_edge != n_att * P) begin
            n_fail++; $display("FAIL %s valid_latency: got %0d expected %0d", name, valid_edge, n_att * P);
        end
        n_tests++;
        if (hold_bad != 0) begin
            n_fail++; $display("FAIL %s hold_while_busy: %0d bad cycles, expected 0", name, hold_bad);
        end
        n_tests++;
        if (secret !== exp_sec || secret_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s secret: got %h/%b expected %h/1", name, secret, secret_valid, exp_sec);
        end
        n_tests++;
        if (retry_cnt !== 4'(exp_retry) || fallback_used !== exp_fb) begin
            n_fail++; $display("FAIL %s retry/fallback: got %0d/%b expected %0d/%b",
                               name, retry_cnt, fallback_used, exp_retry, exp_fb);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL %s busy_after: got %b expected 0", name, busy);
        end
        m_secret = exp_sec;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if ({gen_enable, secret, secret_valid, busy, retry_cnt, fallback_used} !== 24'h0) begin
            n_fail++; $display("FAIL reset_state: got ge=%b s=%h v=%b b=%b r=%0d f=%b expected all 0",
                               gen_enable, secret, secret_valid, busy, retry_cnt, fallback_used);
        end
        m_secret = 16'h0;
    endtask

    task automatic test_accept();
        cand_q = '{16'h3917, 16'h3917, 16'h3917, 16'h3917};
        run_gen("accept", 1'b0);
    endtask

    task automatic test_duplicate();
        cand_q = '{16'h3313, 16'h0482, 16'h0482, 16'h0482};
        run_gen("duplicate", 1'b0);
    endtask

    task automatic test_fallback();
        cand_q = '{16'hA123, 16'hA123, 16'hA123, 16'hA123};
        run_gen("fallback", 1'b0);
    endtask

    task automatic test_handshake();
        cand_q = '{16'h1111, 16'h5678, 16'h5678, 16'h5678};
        run_gen("handshake", 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            cand_q.delete();
            for (int j = 0; j <= MR; j++) begin
                if ($urandom_range(2, 0) == 0) cand_q.push_back(rand_valid());
                else                           cand_q.push_back(16'($urandom));
            end
            run_gen($sformatf("random%0d", k), 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b0;
        repeat ($urandom_range(10, 1)) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if ({gen_enable, secret, secret_valid, busy, retry_cnt, fallback_used} !== 24'h0) begin
            n_fail++; $display("FAIL reset_mid: got ge=%b s=%h v=%b b=%b r=%0d f=%b expected all 0",
                               gen_enable, secret, secret_valid, busy, retry_cnt, fallback_used);
        end
        m_secret = 16'h0;
    endtask

    task automatic test_reset_in_gap();
        int bad = 0;
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (gen_enable !== 1'b0 || secret_valid !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL reset_in_gap: %0d cycles with activity, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_duplicate();
        test_fallback();
        test_handshake();
        test_random();
        test_reset_mid();
        test_reset_in_gap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
